fp_result_display: RTL and testbench

- Downstream consumer of the FP arithmetic kit's selected result.
- Captures one single-precision (32-bit) or double-precision (64-bit) result through a valid/ready handshake and holds it.
- Steps through the held result 16 bits at a time, either on a manual step pulse or automatically.
- Drives a 4-digit multiplexed 7-segment hex display with the current 16-bit word, replacing the static Sel_Out slice select.

---
 rtl/fp_result_display.sv | 154 +++++++++++++++
 tb/tb_fp_result_display.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fp_result_display.sv
// Holds one FP result (single or double) and pages through it 16 bits at a time on a 4-digit 7-seg display.
// Outputs registered (result visible the cycle after accept); in_ready drops when lock is high or reset is asserted.
module fp_result_display #(
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int SCAN_DIV     = 1024
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic        in_double,
  input  logic        lock,
  input  logic        step,
  input  logic        auto_en,
  output logic [1:0]  word_idx,
  output logic [15:0] word,
  output logic        shown,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t        state_q, state_d;
  logic [63:0]   held_q, held_d;
  logic          dbl_q, dbl_d;
  logic [1:0]    idx_q, idx_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [1:0]    dig_q, dig_d;
  logic [15:0]   word_q, word_d;
  logic          shown_q, shown_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          accept;
  logic          advance;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  assign in_ready = Rst & ~lock;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    dbl_d   = dbl_q;
    idx_d   = idx_q;
    dwell_d = dwell_q;
    scan_d  = scan_q;
    dig_d   = dig_q;
    advance = 1'b0;

    if (accept) begin
      held_d  = in_data;
      dbl_d   = in_double;
      idx_d   = 2'd0;
      dwell_d = '0;
      state_d = SHOW;
    end else if (state_q == SHOW) begin
      advance = step | (auto_en & (dwell_q == DWELL_LAST));
      if (advance) begin
        idx_d   = dbl_q ? idx_q + 2'd1 : {1'b0, ~idx_q[0]};
        dwell_d = '0;
      end else if (auto_en) begin
        dwell_d = dwell_q + DW'(1);
      end else begin
        dwell_d = '0;
      end
    end

    // Scan keeps free-running across accepts and advances; only reset re-homes it.
    if (state_q == SHOW) begin
      if (scan_q == SCAN_LAST) begin
        scan_d = '0;
        dig_d  = dig_q + 2'd1;
      end else begin
        scan_d = scan_q + SW'(1);
      end
    end

    // Display fields follow next-state so word and digits change on the same edge.
    if (state_d == SHOW) begin
      shown_d = 1'b1;
      word_d  = held_d[{idx_d, 4'b0000} +: 16];
      an_d    = ~(4'b0001 << dig_d);
      seg_d   = hex7(word_d[{dig_d, 2'b00} +: 4]);
    end else begin
      shown_d = 1'b0;
      word_d  = 16'h0000;
      an_d    = 4'b1111;
      seg_d   = 7'h7F;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= IDLE;
      held_q  <= 64'h0;
      dbl_q   <= 1'b0;
      idx_q   <= 2'd0;
      dwell_q <= '0;
      scan_q  <= '0;
      dig_q   <= 2'd0;
      word_q  <= 16'h0000;
      shown_q <= 1'b0;
      an_q    <= 4'b1111;
      seg_q   <= 7'h7F;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      dbl_q   <= dbl_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      scan_q  <= scan_d;
      dig_q   <= dig_d;
      word_q  <= word_d;
      shown_q <= shown_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign word_idx = idx_q;
  assign word     = word_q;
  assign shown    = shown_q;
  assign an       = an_q;
  assign seg      = seg_q;

endmodule

// File: tb/tb_fp_result_display.sv
// Scoreboarded bench for fp_result_display: a cycle-level reference model queues expectations, a monitor compares.
module tb_fp_result_display;

  localparam int DWELL = 8;
  localparam int SCAN  = 4;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = 64'h0;
  logic        in_double = 1'b0;
  logic        lock = 1'b0;
  logic        step = 1'b0;
  logic        auto_en = 1'b0;
  logic [1:0]  word_idx;
  logic [15:0] word;
  logic        shown;
  logic [3:0]  an;
  logic [6:0]  seg;

  fp_result_display #(.DWELL_CYCLES(DWELL), .SCAN_DIV(SCAN)) dut (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_double(in_double), .lock(lock), .step(step),
    .auto_en(auto_en), .word_idx(word_idx), .word(word), .shown(shown),
    .an(an), .seg(seg)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] word;
    logic [1:0]  idx;
    logic        shown;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        rdy;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   stim_done = 1'b0;

  logic [6:0] hex_tbl [0:15];

  // Reference model state: the held value, its word count, the page index and elapsed SHOW cycles.
  logic [63:0] m_held;
  bit          m_dbl;
  int          m_idx;
  bit          m_shown;
  int          m_dwell;
  int          m_ticks;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit rst, input bit val, input bit lk, input bit st,
                     input bit au, input logic [63:0] d, input bit dbl);
    exp_t e;
    int   dg;
    @(negedge Clk);
    Rst = rst; in_valid = val; lock = lk; step = st; auto_en = au;
    in_data = d; in_double = dbl;
    if (!rst) begin
      m_held = 64'h0; m_dbl = 0; m_idx = 0; m_shown = 0; m_dwell = 0; m_ticks = 0;
    end else begin
      if (m_shown) m_ticks++;
      if (val && !lk) begin
        m_held = d; m_dbl = dbl; m_idx = 0; m_dwell = 0; m_shown = 1;
      end else if (m_shown) begin
        if (st || (au && m_dwell == DWELL - 1)) begin
          m_idx   = (m_idx + 1) % (m_dbl ? 4 : 2);
          m_dwell = 0;
        end else begin
          m_dwell = au ? m_dwell + 1 : 0;
        end
      end
    end
    dg      = (m_ticks / SCAN) % 4;
    e.shown = m_shown;
    e.idx   = 2'(m_idx);
    e.word  = m_shown ? m_held[16*m_idx +: 16] : 16'h0;
    e.an    = m_shown ? ~(4'b0001 << dg) : 4'b1111;
    e.seg   = m_shown ? hex_tbl[e.word[4*dg +: 4]] : 7'h7F;
    e.rdy   = rst && !lk;
    sb.push_back(e);
  endtask

  task automatic idle(input int n, input bit au);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, au, 64'h0, 0);
  endtask

  task automatic stp(input bit au);
    cyc(1, 0, 0, 1, au, 64'h0, 0);
  endtask

  // Monitor: compares the queued expectation 2 time units after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #2;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("in_ready", {63'h0, in_ready}, {63'h0, e.rdy});
        chk("shown",    {63'h0, shown},    {63'h0, e.shown});
        chk("word_idx", {62'h0, word_idx}, {62'h0, e.idx});
        chk("word",     {48'h0, word},     {48'h0, e.word});
        chk("an",       {60'h0, an},       {60'h0, e.an});
        chk("seg",      {57'h0, seg},      {57'h0, e.seg});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit au_r;
    hex_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    m_held = 64'h0; m_dbl = 0; m_idx = 0; m_shown = 0; m_dwell = 0; m_ticks = 0;

    cyc(0, 0, 0, 0, 0, 64'h0, 0);
    cyc(0, 1, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    idle(2, 0);
    cyc(1, 0, 0, 1, 1, 64'h0, 0);

    // Single-precision paging plus a long hold to scan all four digits.
    cyc(1, 1, 0, 0, 0, 64'h0000_0000_428D_8A3D, 0);
    idle(18, 0);
    stp(0); idle(2, 0);
    stp(0); idle(2, 0);

    // Double-precision paging with wrap.
    cyc(1, 1, 0, 0, 0, 64'h4060_BC31_26E9_78D5, 1);
    for (int i = 0; i < 5; i++) begin
      stp(0); idle(1, 0);
    end

    // Auto-advance with a manual step partway through the dwell.
    cyc(1, 1, 0, 0, 1, 64'h4060_BC31_26E9_78D5, 1);
    idle(4, 1);
    stp(1);
    idle(20, 1);

    // Lock blocks accepts; then accept concurrent with step.
    cyc(1, 1, 1, 0, 0, 64'hDEAD_BEEF_0BAD_F00D, 1);
    cyc(1, 0, 1, 1, 0, 64'h0, 0);
    idle(2, 0);
    cyc(1, 1, 0, 1, 0, 64'h1234_5678_9ABC_DEF0, 1);
    idle(1, 0);

    // Reset mid-operation at idx 2.
    stp(0); stp(0);
    cyc(0, 0, 0, 0, 0, 64'h0, 0);
    idle(2, 0);

    au_r = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(15) == 0) au_r = ~au_r;
      cyc(($urandom_range(63) != 0), ($urandom_range(7) == 0), ($urandom_range(3) == 0),
          ($urandom_range(9) == 0), au_r, {$urandom, $urandom}, 1'($urandom_range(1)));
    end
    idle(2, 0);

    repeat (3) @(negedge Clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    stim_done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
